// File: rtl/clk_div_pkg.sv
// clk_div_pkg
// Shared defaults and helpers for the clock-enable bank.
//   CNT_W_DEF       : default divisor/counter width
//   DEFAULT_DIV_DEF : divisor every channel holds after reset
//   div_clamp()     : max(d, 1); a zero divisor is treated as divide-by-one
package clk_div_pkg;

    localparam int CNT_W_DEF       = 26;
    localparam int DEFAULT_DIV_DEF = 2;
    // Width of the clamp helper argument; channels up to this width share it.
    localparam int DIV_ARG_W       = 32;

    // max(d, 1): a zero divisor would never wrap, so it is promoted to 1.
    function automatic logic [DIV_ARG_W-1:0] div_clamp(input logic [DIV_ARG_W-1:0] d);
        logic [DIV_ARG_W-1:0] r;
        if (d == {DIV_ARG_W{1'b0}}) begin
            r = {{(DIV_ARG_W-1){1'b0}}, 1'b1};
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_enable_channel.sv
// clk_enable_channel
// One divider channel: a counter running 0..div-1 while enabled, emitting a
// one-cycle tick and toggling a square-wave level on each wrap. A new divisor
// is staged in pend_div and only swapped in at a wrap, a restart, or while
// the channel is disabled, so no truncated or stretched period is produced.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   en         : run enable (level)
//   restart    : re-phase pulse, highest priority
//   load       : stage load_div (clamped to >= 1) as the pending divisor
//   load_div   : divisor to stage
//   tick       : registered one-cycle strobe every div enabled cycles
//   sq         : registered level, toggles on every tick
//   pending    : a staged divisor is waiting to be applied
module clk_enable_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             tick,
    output logic             sq,
    output logic             pending
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pending_q, pending_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             wrap_s;
    logic             apply_s;

    // div_q is never zero, so div_q-1 cannot underflow.
    assign wrap_s = (cnt_q == (div_q - CNT_W'(1)));

    // Next-state: counter/tick/sq sequencing and divisor hand-over.
    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_div_d = pend_div_q;
        pending_d  = pending_q;
        tick_d     = 1'b0;
        sq_d       = sq_q;
        apply_s    = 1'b0;

        if (restart || !en) begin
            // Restart and disable both return the channel to a fresh phase.
            cnt_d   = {CNT_W{1'b0}};
            sq_d    = 1'b0;
            apply_s = pending_q;
        end else if (wrap_s) begin
            tick_d  = 1'b1;
            sq_d    = ~sq_q;
            cnt_d   = {CNT_W{1'b0}};
            apply_s = pending_q;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
        end

        if (apply_s) begin
            div_d     = pend_div_q;
            pending_d = 1'b0;
        end else begin
            div_d     = div_q;
        end

        // A write in the same cycle as an apply is staged for the next wrap.
        if (load) begin
            pend_div_d = CNT_W'(div_clamp(DIV_ARG_W'(load_div)));
            pending_d  = 1'b1;
        end else begin
            pend_div_d = pend_div_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= {CNT_W{1'b0}};
            div_q      <= CNT_W'(DEFAULT_DIV);
            pend_div_q <= {CNT_W{1'b0}};
            pending_q  <= 1'b0;
            tick_q     <= 1'b0;
            sq_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pending_q  <= pending_d;
            tick_q     <= tick_d;
            sq_q       <= sq_d;
        end
    end

    assign tick    = tick_q;
    assign sq      = sq_q;
    assign pending = pending_q;

endmodule

// File: rtl/clk_enable_bank.sv
// clk_enable_bank
// Bank of NUM_CH runtime-programmable clock-enable channels on one clock.
// Ports:
//   clk, rst_n   : system clock, async active-low reset
//   ch_en        : per-channel run enable
//   sync_restart : one-cycle pulse re-phasing every channel
//   cfg_valid    : divisor write request
//   cfg_ch       : target channel (values >= NUM_CH are accepted and dropped)
//   cfg_div      : new divisor (0 behaves as 1)
//   cfg_ready    : write accepted when cfg_valid && cfg_ready
//   tick         : per-channel one-cycle strobe
//   sq           : per-channel 50%-duty level, period 2*div
//   pending      : per-channel staged-divisor flag
module clk_enable_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_restart,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] pending
);

    logic [NUM_CH-1:0] match_s;
    logic [NUM_CH-1:0] load_s;
    logic              accept_s;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // One-hot decode; an out-of-range cfg_ch matches no channel.
        assign match_s[i] = (cfg_ch == CH_W'(i));

        clk_enable_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (ch_en[i]),
            .restart  (sync_restart),
            .load     (load_s[i]),
            .load_div (cfg_div),
            .tick     (tick[i]),
            .sq       (sq[i]),
            .pending  (pending[i])
        );
    end

    // Busy only when the addressed channel already holds a staged divisor.
    assign cfg_ready = ~|(match_s & pending);
    assign accept_s  = cfg_valid & cfg_ready;
    assign load_s    = match_s & {NUM_CH{accept_s}};

endmodule

// File: tb/tb_clk_enable_bank.sv
module tb_clk_enable_bank;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 26;
    localparam int DEFAULT_DIV = 2;
    localparam int CH_W        = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] ch_en;
    logic              sync_restart;
    logic              cfg_valid;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_ready;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] pending;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [NUM_CH-1:0] t;
        logic [NUM_CH-1:0] s;
        logic [NUM_CH-1:0] p;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: per channel, the number of enabled cycles since the
    // current phase origin; tick/sq follow from division by the period.
    int m_div  [NUM_CH];
    int m_pdiv [NUM_CH];
    bit m_pend [NUM_CH];
    int m_run  [NUM_CH];
    bit m_sqb  [NUM_CH];

    always #5 clk = ~clk;

    clk_enable_bank #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV),
        .CH_W        (CH_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_en        (ch_en),
        .sync_restart (sync_restart),
        .cfg_valid    (cfg_valid),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .cfg_ready    (cfg_ready),
        .tick         (tick),
        .sq           (sq),
        .pending      (pending)
    );

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i]  = DEFAULT_DIV;
            m_pdiv[i] = 0;
            m_pend[i] = 1'b0;
            m_run[i]  = 0;
            m_sqb[i]  = 1'b0;
        end
    endtask

    // One clock cycle: drive inputs after the edge, check cfg_ready, and push
    // the outputs expected after the next edge.
    task automatic cycle(input logic rn, input logic [NUM_CH-1:0] en, input logic rs,
                         input logic v, input logic [CH_W-1:0] ch, input int d);
        exp_t e;
        logic exp_ready;
        logic acc;
        int   c;
        @(posedge clk);
        #2;
        rst_n        = rn;
        ch_en        = en;
        sync_restart = rs;
        cfg_valid    = v;
        cfg_ch       = ch;
        cfg_div      = CNT_W'(d);
        #1;
        c = int'(ch);
        exp_ready = (c >= NUM_CH) ? 1'b1 : !m_pend[c];
        checks++;
        if (cfg_ready !== exp_ready) begin
            failures++;
            $display("FAIL cfg_ready t=%0t ch=%0d got=%b exp=%b", $time, c, cfg_ready, exp_ready);
        end
        acc = v && exp_ready;
        e = '0;
        if (!rn) begin
            model_reset();
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (rs || !en[i]) begin
                    m_run[i] = 0;
                    m_sqb[i] = 1'b0;
                    if (m_pend[i]) begin
                        m_div[i]  = m_pdiv[i];
                        m_pend[i] = 1'b0;
                    end
                end else begin
                    m_run[i]++;
                    e.t[i] = (m_run[i] % m_div[i]) == 0;
                    e.s[i] = m_sqb[i] ^ (((m_run[i] / m_div[i]) % 2) == 1);
                    if (e.t[i] && m_pend[i]) begin
                        m_sqb[i]  = e.s[i];
                        m_run[i]  = 0;
                        m_div[i]  = m_pdiv[i];
                        m_pend[i] = 1'b0;
                    end
                end
            end
            if (acc && c < NUM_CH) begin
                m_pend[c] = 1'b1;
                m_pdiv[c] = (d == 0) ? 1 : d;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                e.p[i] = m_pend[i];
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [NUM_CH-1:0] en);
        for (int k = 0; k < n; k++) begin
            cycle(1'b1, en, 1'b0, 1'b0, '0, 0);
        end
    endtask

    // Monitor: compares DUT outputs to the oldest expectation once per cycle.
    always begin : monitor
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if ({tick, sq, pending} !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got tick=%b sq=%b pend=%b exp tick=%b sq=%b pend=%b",
                         $time, tick, sq, pending, e.t, e.s, e.p);
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        ch_en        = '0;
        sync_restart = 1'b0;
        cfg_valid    = 1'b0;
        cfg_ch       = '0;
        cfg_div      = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tick, sq, pending} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=0", {tick, sq, pending});
        end

        // Channel 0 alone at the default divisor.
        cycle(1'b1, 4'b0001, 1'b0, 1'b0, '0, 0);
        idle(11, 4'b0001);

        // Channel 1: reprogram to 5 mid-period, retry while pending, then ch2.
        cycle(1'b1, 4'b0011, 1'b0, 1'b0, '0, 0);
        cycle(1'b1, 4'b0011, 1'b0, 1'b1, 2'd1, 5);
        cycle(1'b1, 4'b0011, 1'b0, 1'b1, 2'd1, 3);
        cycle(1'b1, 4'b0111, 1'b0, 1'b1, 2'd2, 4);
        idle(20, 4'b0111);

        // D=0 on channel 0 behaves as D=1.
        cycle(1'b1, 4'b0111, 1'b0, 1'b1, 2'd0, 0);
        idle(10, 4'b0111);

        // D=3 / D=7 free-running, then a global restart.
        cycle(1'b1, 4'b0011, 1'b0, 1'b1, 2'd0, 3);
        cycle(1'b1, 4'b0011, 1'b0, 1'b1, 2'd1, 7);
        idle(15, 4'b0011);
        cycle(1'b1, 4'b0011, 1'b1, 1'b0, '0, 0);
        idle(25, 4'b0011);

        // Long divisor, then asynchronous reset mid-count.
        cycle(1'b1, 4'b0011, 1'b0, 1'b1, 2'd0, 1000);
        idle(12, 4'b0011);
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        sb_q.delete();
        model_reset();
        #1;
        checks++;
        if ({tick, sq, pending} !== '0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=0", {tick, sq, pending});
        end
        cycle(1'b0, 4'b0001, 1'b0, 1'b0, '0, 0);
        cycle(1'b1, 4'b0001, 1'b0, 1'b0, '0, 0);
        idle(10, 4'b0001);

        // Randomized traffic.
        for (int k = 0; k < 500; k++) begin
            logic [NUM_CH-1:0] en_r;
            for (int i = 0; i < NUM_CH; i++) begin
                en_r[i] = ($urandom_range(0, 99) < 90);
            end
            cycle(1'b1, en_r, ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 30),
                  CH_W'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 9)));
        end
        idle(2, 4'b1111);

        @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0 entries left", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
